// File: rtl/alu_seq_ctrl_pkg.sv
// Shared opcode, state and ALU-select definitions for the ALU sequencing controller
// and anything that drives or observes it.
package alu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_NOT  = 3'd6,
    OP_CLR  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic s_sub;
    logic s_fas;
    logic s_and;
    logic s_or;
    logic s_xor;
    logic s_not;
  } sel_t;

  localparam int unsigned DATA_W = 16;

  function automatic sel_t decode_sel(input op_e op);
    sel_t s;
    s = '0;
    case (op)
      OP_ADD:  s.s_fas = 1'b1;
      OP_SUB:  begin s.s_fas = 1'b1; s.s_sub = 1'b1; end
      OP_AND:  s.s_and = 1'b1;
      OP_OR:   s.s_or  = 1'b1;
      OP_XOR:  s.s_xor = 1'b1;
      OP_NOT:  s.s_not = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/my_ALU.sv
// Combinational 16-bit ALU driven by one-hot-style selects; lives beside the
// controller at the parent level.
import alu_seq_ctrl_pkg::*;

module my_ALU (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              S_SUB,
  input  logic              S_FAS,
  input  logic              S_AND,
  input  logic              S_OR,
  input  logic              S_XOR,
  input  logic              S_NOT,
  output logic [DATA_W-1:0] R
);

  // Result mux; NOT inverts the accumulator side (A).
  always_comb begin
    R = '0;
    if (S_FAS) begin
      if (S_SUB) begin
        R = A - B;
      end else begin
        R = A + B;
      end
    end else if (S_AND) begin
      R = A & B;
    end else if (S_OR) begin
      R = A | B;
    end else if (S_XOR) begin
      R = A ^ B;
    end else if (S_NOT) begin
      R = ~A;
    end else begin
      R = '0;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer: accepts one command, drives an external ALU for one cycle,
// updates the accumulator and holds the result until the consumer takes it.
import alu_seq_ctrl_pkg::*;

module alu_seq_ctrl (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [2:0]        CMD_OP,
  input  logic [DATA_W-1:0] CMD_DATA,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic              S_SUB,
  output logic              S_FAS,
  output logic              S_AND,
  output logic              S_OR,
  output logic              S_XOR,
  output logic              S_NOT,
  input  logic [DATA_W-1:0] ALU_R,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [DATA_W-1:0] RES_DATA,
  output logic              RES_ZERO,
  output logic              RES_NEG
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  sel_t              sel_q, sel_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              res_valid_q, res_valid_d;

  // Next-state and datapath: selects/operands are loaded on accept so they are
  // valid exactly for the single EXEC cycle.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    sel_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID && cmd_ready_q) begin
          state_d   = ST_EXEC;
          op_d      = op_e'(CMD_OP);
          operand_d = CMD_DATA;
          alu_a_d   = acc_q;
          alu_b_d   = CMD_DATA;
          sel_d     = decode_sel(op_e'(CMD_OP));
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
        case (op_q)
          OP_LOAD: acc_d = operand_q;
          OP_CLR:  acc_d = 16'h0000;
          default: acc_d = ALU_R;
        endcase
      end
      ST_RESP: begin
        if (res_valid_q && RES_READY) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    res_valid_d = (state_d == ST_RESP);
  end

  // State and output registers; reset holds CMD_READY low until the first edge after release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LOAD;
      operand_q   <= 16'h0000;
      acc_q       <= 16'h0000;
      alu_a_q     <= 16'h0000;
      alu_b_q     <= 16'h0000;
      sel_q       <= '0;
      cmd_ready_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      operand_q   <= operand_d;
      acc_q       <= acc_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      sel_q       <= sel_d;
      cmd_ready_q <= cmd_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign CMD_READY = cmd_ready_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = acc_q;
  assign RES_ZERO  = (acc_q == 16'h0000);
  assign RES_NEG   = acc_q[DATA_W-1];
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign S_SUB     = sel_q.s_sub;
  assign S_FAS     = sel_q.s_fas;
  assign S_AND     = sel_q.s_and;
  assign S_OR      = sel_q.s_or;
  assign S_XOR     = sel_q.s_xor;
  assign S_NOT     = sel_q.s_not;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Parent-level bench: controller plus my_ALU, directed commands, and a scoreboard
// monitor that compares every accepted result against hand-computed values.
import alu_seq_ctrl_pkg::*;

module tb_alu_seq_ctrl;

  logic        CLK;
  logic        RST_N;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [2:0]  CMD_OP;
  logic [15:0] CMD_DATA;
  logic [15:0] ALU_A, ALU_B, ALU_R;
  logic        S_SUB, S_FAS, S_AND, S_OR, S_XOR, S_NOT;
  logic        RES_VALID, RES_READY, RES_ZERO, RES_NEG;
  logic [15:0] RES_DATA;

  typedef struct packed {
    logic [15:0] data;
    logic        zero;
    logic        neg;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] prev_acc = 16'h0000;

  localparam logic [5:0] SEL_NONE = 6'b000000;
  localparam logic [5:0] SEL_ADD  = 6'b010000;
  localparam logic [5:0] SEL_SUB  = 6'b110000;
  localparam logic [5:0] SEL_AND  = 6'b001000;
  localparam logic [5:0] SEL_OR   = 6'b000100;
  localparam logic [5:0] SEL_XOR  = 6'b000010;
  localparam logic [5:0] SEL_NOT  = 6'b000001;

  alu_seq_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .S_SUB(S_SUB), .S_FAS(S_FAS), .S_AND(S_AND), .S_OR(S_OR), .S_XOR(S_XOR),
    .S_NOT(S_NOT), .ALU_R(ALU_R), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_DATA(RES_DATA), .RES_ZERO(RES_ZERO), .RES_NEG(RES_NEG)
  );

  my_ALU alu (
    .A(ALU_A), .B(ALU_B), .S_SUB(S_SUB), .S_FAS(S_FAS), .S_AND(S_AND),
    .S_OR(S_OR), .S_XOR(S_XOR), .S_NOT(S_NOT), .R(ALU_R)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] sels();
    return {S_SUB, S_FAS, S_AND, S_OR, S_XOR, S_NOT};
  endfunction

  // Scoreboard monitor: each result handshake pops one expected entry.
  always @(negedge CLK) begin
    if (RST_N && RES_VALID && RES_READY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(RES_DATA), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_data", 32'(RES_DATA), 32'(e.data));
        check("res_zero", 32'(RES_ZERO), 32'(e.zero));
        check("res_neg",  32'(RES_NEG),  32'(e.neg));
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (CMD_READY) break;
      @(negedge CLK);
    end
    if (!CMD_READY) check("cmd_ready_timeout", 32'(CMD_READY), 32'd1);
  endtask

  // Issue one command at a negedge, check the EXEC cycle and the first RESP cycle.
  task automatic do_cmd(input op_e op, input logic [15:0] d, input logic [15:0] exp,
                        input logic [5:0] esel, input logic push);
    exp_t e;
    wait_ready();
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_DATA  = d;
    if (push) begin
      e.data = exp;
      e.zero = (exp == 16'h0000);
      e.neg  = exp[15];
      exp_q.push_back(e);
    end
    @(negedge CLK);
    CMD_VALID = 1'b0;
    check("exec_sel",   32'(sels()),    32'(esel));
    check("exec_alu_a", 32'(ALU_A),     32'(prev_acc));
    check("exec_alu_b", 32'(ALU_B),     32'(d));
    check("exec_ready", 32'(CMD_READY), 32'd0);
    if (push) begin
      prev_acc = exp;
      @(negedge CLK);
      check("resp_sel",   32'(sels()),    32'(SEL_NONE));
      check("resp_valid", 32'(RES_VALID), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N     = 1'b1;
    CMD_VALID = 1'b0;
    CMD_OP    = 3'd0;
    CMD_DATA  = 16'h0000;
    RES_READY = 1'b1;
    #1 RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_cmd_ready", 32'(CMD_READY), 32'd0);
    check("rst_res_valid", 32'(RES_VALID), 32'd0);
    check("rst_res_data",  32'(RES_DATA),  32'd0);
    check("rst_sel",       32'(sels()),    32'(SEL_NONE));
    RST_N = 1'b1;
    #1 check("ready_before_edge", 32'(CMD_READY), 32'd0);
    @(negedge CLK);
    check("ready_after_edge", 32'(CMD_READY), 32'd1);

    do_cmd(OP_LOAD, 16'd65280, 16'd65280, SEL_NONE, 1'b1);
    do_cmd(OP_ADD,  16'd257,   16'd1,     SEL_ADD,  1'b1);
    do_cmd(OP_LOAD, 16'd16,    16'd16,    SEL_NONE, 1'b1);
    do_cmd(OP_SUB,  16'd9,     16'd7,     SEL_SUB,  1'b1);
    do_cmd(OP_LOAD, 16'd65280, 16'd65280, SEL_NONE, 1'b1);
    do_cmd(OP_AND,  16'd255,   16'd0,     SEL_AND,  1'b1);
    do_cmd(OP_OR,   16'd43520, 16'd43520, SEL_OR,   1'b1);
    do_cmd(OP_LOAD, 16'd0,     16'd0,     SEL_NONE, 1'b1);
    do_cmd(OP_NOT,  16'h1234,  16'hFFFF,  SEL_NOT,  1'b1);
    do_cmd(OP_CLR,  16'h5555,  16'h0000,  SEL_NONE, 1'b1);
    do_cmd(OP_XOR,  16'h0F0F,  16'h0F0F,  SEL_XOR,  1'b1);
    do_cmd(OP_SUB,  16'h0F10,  16'hFFFF,  SEL_SUB,  1'b1);

    // Consumer stall with a competing command that must not be taken.
    wait_ready();
    RES_READY = 1'b0;
    do_cmd(OP_LOAD, 16'h1234, 16'h1234, SEL_NONE, 1'b1);
    for (int i = 0; i < 5; i++) begin
      CMD_VALID = 1'b1;
      CMD_OP    = OP_CLR;
      CMD_DATA  = 16'h0000;
      check("stall_valid", 32'(RES_VALID), 32'd1);
      check("stall_data",  32'(RES_DATA),  32'h1234);
      check("stall_ready", 32'(CMD_READY), 32'd0);
      @(negedge CLK);
    end
    CMD_VALID = 1'b0;
    @(posedge CLK);
    #1 RES_READY = 1'b1;
    do_cmd(OP_ADD, 16'd1, 16'h1235, SEL_ADD, 1'b1);

    // Reset in the EXEC cycle of an ADD after LOAD 5.
    do_cmd(OP_LOAD, 16'd5, 16'd5, SEL_NONE, 1'b1);
    do_cmd(OP_ADD, 16'd3, 16'd8, SEL_ADD, 1'b0);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_data",  32'(RES_DATA),  32'd0);
    check("mid_rst_valid", 32'(RES_VALID), 32'd0);
    check("mid_rst_sel",   32'(sels()),    32'(SEL_NONE));
    check("mid_rst_ready", 32'(CMD_READY), 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    check("post_rst_ready", 32'(CMD_READY), 32'd1);
    check("post_rst_valid", 32'(RES_VALID), 32'd0);
    prev_acc = 16'h0000;
    do_cmd(OP_ADD, 16'd7, 16'd7, SEL_ADD, 1'b1);

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge CLK);
    end
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, single clock; all state changes on rising edge.
REQ-002 SHALL have port RST_N, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port CMD_VALID, input, 1, command present.
REQ-004 SHALL have port CMD_READY, output, 1, command accepted when high with CMD_VALID.
REQ-005 SHALL have port CMD_OP, input, 3, opcode: 0 LOAD, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 CLR.
REQ-006 SHALL have port CMD_DATA, input, 16, operand.
REQ-007 SHALL have ports ALU_A and ALU_B, output, 16 each, ALU operands.
REQ-008 SHALL have ports S_SUB, S_FAS, S_AND, S_OR, S_XOR and S_NOT, output, 1 each, ALU selects.
REQ-009 SHALL have port ALU_R, input, 16, combinational ALU result.
REQ-010 SHALL have port RES_VALID, output, 1, result available.
REQ-011 SHALL have port RES_READY, input, 1, consumer accepts result.
REQ-012 SHALL have port RES_DATA, output, 16, accumulator value.
REQ-013 SHALL have ports RES_ZERO and RES_NEG, output, 1 each, RES_DATA==0 and RES_DATA[15].

Function
REQ-014 SHALL implement a three-state FSM: IDLE, EXEC, RESP.
REQ-015 IDLE SHALL drive CMD_READY=1; all other states SHALL drive CMD_READY=0.
REQ-016 In IDLE, CMD_VALID&CMD_READY at an edge SHALL latch CMD_OP/CMD_DATA into op/operand registers and move to EXEC.
REQ-017 EXEC SHALL last exactly one cycle and drive ALU_A=ACC and ALU_B=operand register.
REQ-018 In EXEC, selects SHALL be: ADD S_FAS; SUB S_FAS+S_SUB; AND S_AND; OR S_OR; XOR S_XOR; NOT S_NOT.
REQ-019 LOAD and CLR SHALL drive all selects 0 and ignore ALU_R.
REQ-020 Outside EXEC, all six selects SHALL be 0 and ALU_A/ALU_B SHALL keep their last registered values.
REQ-021 At the EXEC-to-RESP edge, ACC SHALL load: operand (LOAD), 0 (CLR), or ALU_R (all other ops).
REQ-022 Arithmetic SHALL be 16-bit modulo with no carry or overflow output.
REQ-023 RESP SHALL hold RES_VALID=1 and a stable RES_DATA until RES_VALID&RES_READY at an edge, then return to IDLE.
REQ-024 RES_DATA SHALL always equal ACC, with RES_ZERO/RES_NEG derived combinationally from ACC.
REQ-025 Command-to-RES_VALID latency SHALL be 2 edges; minimum command period SHALL be 3 cycles.
REQ-026 RES_READY held high before RESP SHALL have no effect; CMD_VALID outside IDLE SHALL be ignored.
REQ-027 CMD_DATA SHALL be ignored for NOT and CLR, but still registered onto ALU_B.

Reset
REQ-028 RST_N low SHALL immediately force state IDLE, ACC=0, operand/op=0, all selects=0, RES_VALID=0, CMD_READY=0 while low.
REQ-029 Reset during EXEC or RESP SHALL discard the command without an ACC update.
REQ-030 CMD_READY SHALL rise at the first edge after RST_N deasserts.

Structure
REQ-031 Opcode constants and FSM state encodings SHALL live in a shared package/header used by this block and its bench.
REQ-032 The block SHALL contain no sub-module; my_ALU SHALL be instantiated beside it at the parent level, ALU_A/ALU_B/selects -> my_ALU and my_ALU R -> ALU_R.

Verification
REQ-033 Bench SHALL check LOAD 65280 then ADD 257 -> RES_DATA=1, RES_ZERO=0, RES_NEG=0.
REQ-034 Bench SHALL check LOAD 16 then SUB 9 -> RES_DATA=7, with S_FAS=S_SUB=1 only during EXEC.
REQ-035 Bench SHALL check LOAD 65280, AND 255 -> RES_DATA=0, RES_ZERO=1; then OR 43520 -> 43520, RES_NEG=1.
REQ-036 Bench SHALL check NOT after LOAD 0 -> 65535; CLR -> 0, RES_ZERO=1.
REQ-037 Bench SHALL hold RES_READY=0 for 5 cycles -> RES_VALID, RES_DATA and CMD_READY=0 stable, with the second CMD_VALID not accepted.
REQ-038 Bench SHALL drop RST_N during EXEC of ADD after LOAD 5 -> immediately ACC=0, RES_VALID=0, selects=0; after release CMD_READY=1.
